// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks (multiplier, divider).
// Holds default operand geometry, the control FSM encoding and a counter-width helper.
// No logic; imported by every fixed-point module.
package fixed_point_pkg;

    // Default operand format: UQ6.4
    localparam int WIDTH_DEF = 10;
    localparam int FRAC_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must be able to hold the value WIDTH
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fixed_multiplier_datapath.sv
// Shift-add datapath: B/Q/acc registers, WIDTH+1 adder, right shifter, zero detect.
// Latency: one shift-add step per cycle while shift is high; load takes effect on the same edge.
// Backpressure: none; controlled entirely by load/shift from the FSM.
//
// Ports: clock/reset (async active-low), load (capture operands, clear acc),
//        shift (one radix-2 step), a_in/b_in operands, p_out/ovf decoded from
//        the held {acc,Q} product, zero_op registered at load.
module fixed_multiplier_datapath
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] p_out,
    output logic             ovf,
    output logic             zero_op
);

    logic [WIDTH-1:0]   b_q,   b_d;
    logic [WIDTH-1:0]   q_q,   q_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               zero_q, zero_d;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        b_d    = b_q;
        q_d    = q_q;
        acc_d  = acc_q;
        zero_d = zero_q;
        // Partial product is B gated by the current multiplier LSB
        sum    = {1'b0, acc_q} + ({1'b0, b_q} & {(WIDTH+1){q_q[0]}});
        if (load) begin
            b_d    = b_in;
            q_d    = a_in;
            acc_d  = '0;
            zero_d = (a_in == '0) || (b_in == '0);
        end else if (shift) begin
            // {acc,Q} <= {sum,Q} >> 1 : sum LSB drops into the top of Q
            acc_d = sum[WIDTH:1];
            q_d   = {sum[0], q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            b_q    <= '0;
            q_q    <= '0;
            acc_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            b_q    <= b_d;
            q_q    <= q_d;
            acc_q  <= acc_d;
            zero_q <= zero_d;
        end
    end

    // Raw 2*WIDTH product; result is the truncated middle slice, anything
    // above it is integer overflow.
    assign prod    = {acc_q, q_q};
    assign p_out   = WIDTH'(prod >> FRAC);
    assign ovf     = |(prod >> (FRAC + WIDTH));
    assign zero_op = zero_q;

endmodule

// File: rtl/fixed_multiplier_10.sv
// Sequential unsigned fixed-point multiplier, p = (a*b)>>FRAC truncated, ovf flagged.
// Latency: done pulses in the cycle after edge k+WIDTH, where k is the accepting edge.
// Backpressure: start is sampled only in IDLE; ignored while busy or during DONE.
//
// Ports: clock, reset (async active-low), start, par_in_a, par_in_b,
//        busy, done, par_out_p, ovf, zero_op.
module fixed_multiplier_10
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] par_in_a,
    input  logic [WIDTH-1:0] par_in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] par_out_p,
    output logic             ovf,
    output logic             zero_op
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             load;
    logic             shift;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                shift = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                // The edge that performs the WIDTH-th step leaves CALC
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_CALC);
    assign done = (state_q == ST_DONE);

    fixed_multiplier_datapath #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_datapath (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .a_in    (par_in_a),
        .b_in    (par_in_b),
        .p_out   (par_out_p),
        .ovf     (ovf),
        .zero_op (zero_op)
    );

endmodule

// File: tb/tb_fixed_multiplier_10.sv
// Directed bench for fixed_multiplier_10 (UQ6.4 defaults).
// Drives on the falling edge, samples on the falling edge after each rising edge.
// Expected values are hand-computed constants.
module tb_fixed_multiplier_10;

    logic       clock;
    logic       reset;
    logic       start;
    logic [9:0] par_in_a;
    logic [9:0] par_in_b;
    logic       busy;
    logic       done;
    logic [9:0] par_out_p;
    logic       ovf;
    logic       zero_op;

    int n_tests = 0;
    int n_fail  = 0;

    fixed_multiplier_10 dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .par_in_a  (par_in_a),
        .par_in_b  (par_in_b),
        .busy      (busy),
        .done      (done),
        .par_out_p (par_out_p),
        .ovf       (ovf),
        .zero_op   (zero_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation: latency, busy length, single-cycle done, results.
    task automatic op(input string tag, input logic [9:0] a, input logic [9:0] b,
                      input logic [9:0] ep, input logic eovf, input logic ezero);
        int lat;
        int busy_cnt;
        @(negedge clock);
        par_in_a = a;
        par_in_b = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        par_in_a = 10'($urandom);
        par_in_b = 10'($urandom);
        lat      = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_cnt++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd11);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd10);
        chk({tag, "_p"}, 32'(par_out_p), 32'(ep));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        chk({tag, "_zero_op"}, 32'(zero_op), 32'(ezero));
        @(negedge clock);
        chk({tag, "_done_width"}, 32'(done), 32'd0);
        chk({tag, "_p_held"}, 32'(par_out_p), 32'(ep));
    endtask

    initial begin
        int dones;
        int guard;
        reset    = 1'b0;
        start    = 1'b0;
        par_in_a = '0;
        par_in_b = '0;

        // Reset state
        @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_p", 32'(par_out_p), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_zero_op", 32'(zero_op), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Directed vectors
        op("t1_1x2p5",   10'h010, 10'h028, 10'h028, 1'b0, 1'b0);
        op("t2_max",     10'h3FF, 10'h3FF, 10'h380, 1'b1, 1'b0);
        op("t3_15x4",    10'h0F0, 10'h040, 10'h3C0, 1'b0, 1'b0);
        op("t3_16x4",    10'h100, 10'h040, 10'h000, 1'b1, 1'b0);
        op("t4_lsb",     10'h001, 10'h001, 10'h000, 1'b0, 1'b0);
        op("t4_zero",    10'h000, 10'h155, 10'h000, 1'b0, 1'b1);

        // Start held high, inputs changed mid-op
        @(negedge clock);
        par_in_a = 10'h0F0;
        par_in_b = 10'h040;
        start    = 1'b1;
        @(posedge clock);
        #1;
        par_in_a = 10'h020;
        par_in_b = 10'h030;
        dones    = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clock);
            if (done) dones++;
        end
        chk("t5_one_done", 32'(dones), 32'd1);
        chk("t5_p", 32'(par_out_p), 32'h3C0);
        chk("t5_ovf", 32'(ovf), 32'd0);
        @(negedge clock);
        chk("t5_idle_gap", 32'(busy), 32'd0);
        @(negedge clock);
        chk("t5_reaccept", 32'(busy), 32'd1);
        start = 1'b0;
        guard = 0;
        while (!done && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        chk("t5_second_done_seen", 32'(done), 32'd1);
        chk("t5_second_p", 32'(par_out_p), 32'h060);

        // Reset in the 5th CALC cycle
        @(negedge clock);
        par_in_a = 10'h3FF;
        par_in_b = 10'h3FF;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clock);
        chk("t6_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_p", 32'(par_out_p), 32'd0);
        chk("t6_ovf", 32'(ovf), 32'd0);
        chk("t6_zero_op", 32'(zero_op), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (done || busy) dones++;
        end
        chk("t6_no_done_after_abort", 32'(dones), 32'd0);
        op("t6_after", 10'h020, 10'h030, 10'h060, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
